// File: rtl/sm3_pkg.sv
// ----------------------------------------------------------------------------
// sm3_pkg
//   Shared types and constants for the SM3 message padder.
//   - sm3_pad_st_e : padder FSM states
//   - SM3_BLK_BITS : SM3 compression block size in bits
//   - SM3_LEN_BITS : width of the trailing message-length field in bits
// ----------------------------------------------------------------------------
package sm3_pkg;

   typedef enum logic [1:0] {
      S_DATA = 2'd0,
      S_P80  = 2'd1,
      S_ZERO = 2'd2,
      S_LEN  = 2'd3
   } sm3_pad_st_e;

   localparam int SM3_BLK_BITS = 512;
   localparam int SM3_LEN_BITS = 64;

endpackage

// File: rtl/sm3_pad_last_word.sv
// ----------------------------------------------------------------------------
// sm3_pad_last_word
//   Combinational shaping of the final message beat.
//   Ports:
//     i_d        in  W     last message word, first byte in [W-1:W-8]
//     i_vld_byte in  W/8   valid-byte mask, MSB = first byte
//     o_d        out W     word with invalid bytes zeroed and 0x80 marker inserted
//                          after the last valid byte (no marker when all bytes valid)
//     o_full     out 1     all W/8 bytes valid; marker must go in a separate word
//     o_bits     out 8     number of message bits contributed by this beat (8*k)
// ----------------------------------------------------------------------------
module sm3_pad_last_word #(
   parameter int W = 32
) (
   input  logic [W-1:0]   i_d,
   input  logic [W/8-1:0] i_vld_byte,
   output logic [W-1:0]   o_d,
   output logic           o_full,
   output logic [7:0]     o_bits
);

   localparam int NB = W / 8;
   localparam int KW = $clog2(NB + 1);

   logic [KW-1:0] w_k;
   logic          w_run;

   // k counts leading ones only; any set bit after the first zero is ignored.
   always_comb begin
      w_k   = '0;
      w_run = 1'b1;
      for (int j = 0; j < NB; j++) begin
         if (w_run && i_vld_byte[NB-1-j]) begin
            w_k = w_k + 1'b1;
         end else begin
            w_run = 1'b0;
         end
      end
   end

   always_comb begin
      o_d = '0;
      for (int j = 0; j < NB; j++) begin
         if (KW'(j) < w_k) begin
            o_d[W-1-8*j -: 8] = i_d[W-1-8*j -: 8];
         end else if (KW'(j) == w_k) begin
            o_d[W-1-8*j -: 8] = 8'h80;
         end
      end
   end

   assign o_full = (w_k == KW'(NB));
   assign o_bits = 8'({w_k, 3'b000});

endmodule

// File: rtl/sm3_pad_stream.sv
// ----------------------------------------------------------------------------
// sm3_pad_stream
//   SM3 message padder. Accepts a byte-granular message stream W bits wide and
//   emits data, 0x80 marker, zero fill and the 64-bit big-endian bit length so
//   the output is a whole number of 512-bit blocks.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     msg_inpt_d_i         W    message word (first byte in MSBs)
//     msg_inpt_vld_byte_i  W/8  valid-byte mask (MSB = first byte)
//     msg_inpt_vld_i       1    input beat valid
//     msg_inpt_lst_i       1    final beat of message
//     msg_inpt_rdy_o       1    input ready
//     pad_otpt_d_o         W    padded output word
//     pad_otpt_vld_o       1    output valid
//     pad_otpt_rdy_i       1    downstream ready
//     pad_otpt_blk_end_o   1    last word of a 512-bit block
//     pad_otpt_lst_o       1    last word of the padded message
//     pad_busy_o           1    message in progress
// ----------------------------------------------------------------------------
module sm3_pad_stream
   import sm3_pkg::*;
#(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   msg_inpt_d_i,
   input  logic [W/8-1:0] msg_inpt_vld_byte_i,
   input  logic           msg_inpt_vld_i,
   input  logic           msg_inpt_lst_i,
   output logic           msg_inpt_rdy_o,
   output logic [W-1:0]   pad_otpt_d_o,
   output logic           pad_otpt_vld_o,
   input  logic           pad_otpt_rdy_i,
   output logic           pad_otpt_blk_end_o,
   output logic           pad_otpt_lst_o,
   output logic           pad_busy_o
);

   localparam int WPB = SM3_BLK_BITS / W;
   localparam int LW  = SM3_LEN_BITS / W;
   localparam int WCW = $clog2(WPB);

   localparam logic [WCW-1:0] WC_LEN0 = WCW'(WPB - LW);
   localparam logic [WCW-1:0] WC_LAST = WCW'(WPB - 1);

   if (W != 32 && W != 64) begin : g_bad_w
      $error("sm3_pad_stream: W must be 32 or 64");
   end

   sm3_pad_st_e  r_state;
   logic [WCW-1:0] r_wc;
   logic [63:0]  r_bitcnt;
   logic [W-1:0] r_d;
   logic         r_vld;
   logic         r_blk_end;
   logic         r_lst;
   logic         r_busy;

   logic [W-1:0]   w_lw_d;
   logic           w_lw_full;
   logic [7:0]     w_lw_bits;
   logic           w_free;
   logic           w_in_acc;
   logic           w_out_xfer;
   logic [WCW-1:0] w_wc_nxt;
   logic [WCW-1:0] w_len_idx;
   logic [W-1:0]   w_len_word;
   sm3_pad_st_e    w_tail_st;

   sm3_pad_last_word #(.W(W)) u_last_word (
      .i_d        (msg_inpt_d_i),
      .i_vld_byte (msg_inpt_vld_byte_i),
      .o_d        (w_lw_d),
      .o_full     (w_lw_full),
      .o_bits     (w_lw_bits)
   );

   assign w_free     = !r_vld || pad_otpt_rdy_i;
   assign w_out_xfer = r_vld && pad_otpt_rdy_i;
   assign w_in_acc   = msg_inpt_vld_i && msg_inpt_rdy_o;

   // r_wc is the block position of the next word to be loaded into the output
   // register; it tracks transfers one-for-one because every load is transferred.
   assign w_wc_nxt  = r_wc + 1'b1;
   assign w_len_idx = r_wc - WC_LEN0;

   // After a marker or zero word, go straight to the length field when the next
   // slot is the first length slot; otherwise keep filling zeros (possibly
   // across a block boundary, which yields the extra block).
   assign w_tail_st = (w_wc_nxt == WC_LEN0) ? S_LEN : S_ZERO;

   // Length is emitted most-significant word first.
   always_comb begin
      w_len_word = '0;
      for (int j = 0; j < LW; j++) begin
         if (w_len_idx == WCW'(j)) begin
            w_len_word = r_bitcnt[SM3_LEN_BITS-1-j*W -: W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_DATA;
         r_wc      <= '0;
         r_bitcnt  <= '0;
         r_d       <= '0;
         r_vld     <= 1'b0;
         r_blk_end <= 1'b0;
         r_lst     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         // Drain: flags drop with valid so no stale qualifier is left visible.
         if (w_out_xfer) begin
            r_vld     <= 1'b0;
            r_blk_end <= 1'b0;
            r_lst     <= 1'b0;
            if (r_lst) begin
               r_busy <= 1'b0;
            end
         end

         if (w_free) begin
            case (r_state)
               S_DATA: begin
                  if (w_in_acc) begin
                     r_vld     <= 1'b1;
                     r_wc      <= w_wc_nxt;
                     r_blk_end <= (r_wc == WC_LAST);
                     r_lst     <= 1'b0;
                     r_busy    <= 1'b1;
                     if (msg_inpt_lst_i) begin
                        r_d      <= w_lw_d;
                        r_bitcnt <= r_bitcnt + 64'(w_lw_bits);
                        r_state  <= w_lw_full ? S_P80 : w_tail_st;
                     end else begin
                        r_d      <= msg_inpt_d_i;
                        r_bitcnt <= r_bitcnt + 64'(W);
                     end
                  end
               end
               S_P80: begin
                  r_vld     <= 1'b1;
                  r_wc      <= w_wc_nxt;
                  r_blk_end <= (r_wc == WC_LAST);
                  r_lst     <= 1'b0;
                  r_d       <= {8'h80, {(W-8){1'b0}}};
                  r_state   <= w_tail_st;
               end
               S_ZERO: begin
                  r_vld     <= 1'b1;
                  r_wc      <= w_wc_nxt;
                  r_blk_end <= (r_wc == WC_LAST);
                  r_lst     <= 1'b0;
                  r_d       <= '0;
                  r_state   <= w_tail_st;
               end
               S_LEN: begin
                  r_vld     <= 1'b1;
                  r_wc      <= w_wc_nxt;
                  r_blk_end <= (r_wc == WC_LAST);
                  r_d       <= w_len_word;
                  r_lst     <= (r_wc == WC_LAST);
                  if (r_wc == WC_LAST) begin
                     // Length word already captured from the old count above.
                     r_bitcnt <= '0;
                     r_state  <= S_DATA;
                  end
               end
               default: r_state <= S_DATA;
            endcase
         end
      end
   end

   assign msg_inpt_rdy_o     = (r_state == S_DATA) && w_free;
   assign pad_otpt_d_o       = r_d;
   assign pad_otpt_vld_o     = r_vld;
   assign pad_otpt_blk_end_o = r_blk_end;
   assign pad_otpt_lst_o     = r_lst;
   assign pad_busy_o         = r_busy;

endmodule

// File: tb/tb_sm3_pad_stream.sv
module tb_sm3_pad_stream;

   logic clk;
   logic rst;

   // W=32 instance
   logic [31:0] m32_d;
   logic [3:0]  m32_mask;
   logic        m32_vld, m32_lst, m32_rdy;
   logic [31:0] o32_d;
   logic        o32_vld, p32_rdy, o32_be, o32_lst, o32_busy;

   // W=64 instance
   logic [63:0] m64_d;
   logic [7:0]  m64_mask;
   logic        m64_vld, m64_lst, m64_rdy;
   logic [63:0] o64_d;
   logic        o64_vld, p64_rdy, o64_be, o64_lst, o64_busy;

   int n_cmp;
   int n_fail;

   logic [31:0] q32_d[$];
   bit          q32_be[$];
   bit          q32_lst[$];
   bit          saw_lst32;
   logic [63:0] q64_d[$];
   bit          q64_be[$];
   bit          q64_lst[$];
   bit          saw_lst64;

   bit          rnd32;
   bit          chk_stall;

   sm3_pad_stream #(.W(32)) dut32 (
      .clk                 (clk),
      .rst                 (rst),
      .msg_inpt_d_i        (m32_d),
      .msg_inpt_vld_byte_i (m32_mask),
      .msg_inpt_vld_i      (m32_vld),
      .msg_inpt_lst_i      (m32_lst),
      .msg_inpt_rdy_o      (m32_rdy),
      .pad_otpt_d_o        (o32_d),
      .pad_otpt_vld_o      (o32_vld),
      .pad_otpt_rdy_i      (p32_rdy),
      .pad_otpt_blk_end_o  (o32_be),
      .pad_otpt_lst_o      (o32_lst),
      .pad_busy_o          (o32_busy)
   );

   sm3_pad_stream #(.W(64)) dut64 (
      .clk                 (clk),
      .rst                 (rst),
      .msg_inpt_d_i        (m64_d),
      .msg_inpt_vld_byte_i (m64_mask),
      .msg_inpt_vld_i      (m64_vld),
      .msg_inpt_lst_i      (m64_lst),
      .msg_inpt_rdy_o      (m64_rdy),
      .pad_otpt_d_o        (o64_d),
      .pad_otpt_vld_o      (o64_vld),
      .pad_otpt_rdy_i      (p64_rdy),
      .pad_otpt_blk_end_o  (o64_be),
      .pad_otpt_lst_o      (o64_lst),
      .pad_busy_o          (o64_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Downstream ready for the 32-bit instance: always 1, or random when enabled.
   initial begin
      p32_rdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         p32_rdy = rnd32 ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output capture at the falling edge; a word seen with vld&rdy here
   // transfers on the next rising edge. Also checks hold-under-stall.
   initial begin : mon32
      logic [31:0] prev_d;
      bit          prev_be, prev_lst, prev_st;
      prev_st = 1'b0;
      prev_d  = '0;
      prev_be = 1'b0;
      prev_lst = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_st = 1'b0;
         end else begin
            if (chk_stall && prev_st) begin
               n_cmp++;
               if (o32_vld !== 1'b1 || o32_d !== prev_d || o32_be !== prev_be || o32_lst !== prev_lst) begin
                  n_fail++;
                  $display("FAIL stall_hold got vld=%b d=%h be=%b lst=%b want vld=1 d=%h be=%b lst=%b",
                           o32_vld, o32_d, o32_be, o32_lst, prev_d, prev_be, prev_lst);
               end
            end
            if (o32_vld && p32_rdy) begin
               q32_d.push_back(o32_d);
               q32_be.push_back(o32_be);
               q32_lst.push_back(o32_lst);
               if (o32_lst) saw_lst32 = 1'b1;
            end
            prev_st  = o32_vld && !p32_rdy;
            prev_d   = o32_d;
            prev_be  = o32_be;
            prev_lst = o32_lst;
         end
      end
   end

   initial begin : mon64
      forever begin
         @(negedge clk);
         if (!rst && o64_vld && p64_rdy) begin
            q64_d.push_back(o64_d);
            q64_be.push_back(o64_be);
            q64_lst.push_back(o64_lst);
            if (o64_lst) saw_lst64 = 1'b1;
         end
      end
   end

   function automatic logic [31:0] pat_word(input int w);
      return {8'(4*w+1), 8'(4*w+2), 8'(4*w+3), 8'(4*w+4)};
   endfunction

   task automatic clear_q();
      q32_d.delete(); q32_be.delete(); q32_lst.delete(); saw_lst32 = 1'b0;
      q64_d.delete(); q64_be.delete(); q64_lst.delete(); saw_lst64 = 1'b0;
   endtask

   task automatic send32(input logic [31:0] d, input logic [3:0] m, input logic l);
      int t;
      m32_d = d; m32_mask = m; m32_lst = l; m32_vld = 1'b1;
      t = 0;
      @(negedge clk);
      while (!m32_rdy && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!m32_rdy) begin
         n_cmp++; n_fail++;
         $display("FAIL send32_timeout got rdy=0 want rdy=1 within 2000 cycles");
      end
      @(posedge clk);
      #1;
      m32_vld = 1'b0; m32_lst = 1'b0;
   endtask

   task automatic send64(input logic [63:0] d, input logic [7:0] m, input logic l);
      int t;
      m64_d = d; m64_mask = m; m64_lst = l; m64_vld = 1'b1;
      t = 0;
      @(negedge clk);
      while (!m64_rdy && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!m64_rdy) begin
         n_cmp++; n_fail++;
         $display("FAIL send64_timeout got rdy=0 want rdy=1 within 2000 cycles");
      end
      @(posedge clk);
      #1;
      m64_vld = 1'b0; m64_lst = 1'b0;
   endtask

   task automatic wait_lst32(input int budget);
      int t;
      t = 0;
      while (!saw_lst32 && t < budget) begin
         @(posedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      if (!saw_lst32) begin
         n_cmp++; n_fail++;
         $display("FAIL wait_lst32 got no last word want one within %0d cycles", budget);
      end
   endtask

   task automatic wait_lst64(input int budget);
      int t;
      t = 0;
      while (!saw_lst64 && t < budget) begin
         @(posedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      if (!saw_lst64) begin
         n_cmp++; n_fail++;
         $display("FAIL wait_lst64 got no last word want one within %0d cycles", budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (o32_vld !== 1'b0 || o32_d !== 32'h0 || o32_be !== 1'b0 || o32_lst !== 1'b0 ||
          o32_busy !== 1'b0 || m32_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset32 got vld=%b d=%h be=%b lst=%b busy=%b rdy=%b want 0 0 0 0 0 1",
                  o32_vld, o32_d, o32_be, o32_lst, o32_busy, m32_rdy);
      end
      n_cmp++;
      if (o64_vld !== 1'b0 || o64_d !== 64'h0 || o64_be !== 1'b0 || o64_lst !== 1'b0 ||
          o64_busy !== 1'b0 || m64_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset64 got vld=%b d=%h be=%b lst=%b busy=%b rdy=%b want 0 0 0 0 0 1",
                  o64_vld, o64_d, o64_be, o64_lst, o64_busy, m64_rdy);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_abc32();
      logic [31:0] ed[$];
      clear_q();
      send32(32'h616263EE, 4'b1110, 1'b1);
      n_cmp++;
      if (o32_vld !== 1'b1 || o32_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL abc32_latency got vld=%b busy=%b want 1 1", o32_vld, o32_busy);
      end
      wait_lst32(200);
      ed.push_back(32'h61626380);
      repeat (14) ed.push_back(32'h0);
      ed.push_back(32'h18);
      n_cmp++;
      if (q32_d.size() !== ed.size()) begin
         n_fail++;
         $display("FAIL abc32_count got %0d want %0d", q32_d.size(), ed.size());
      end
      for (int i = 0; i < ed.size() && i < q32_d.size(); i++) begin
         n_cmp++;
         if (q32_d[i] !== ed[i] || q32_be[i] !== (i % 16 == 15) || q32_lst[i] !== (i == ed.size() - 1)) begin
            n_fail++;
            $display("FAIL abc32_word%0d got d=%h be=%b lst=%b want d=%h be=%b lst=%b", i,
                     q32_d[i], q32_be[i], q32_lst[i], ed[i], (i % 16 == 15), (i == ed.size() - 1));
         end
      end
      n_cmp++;
      if (o32_busy !== 1'b0 || o32_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL abc32_idle got busy=%b vld=%b want 0 0", o32_busy, o32_vld);
      end
   endtask

   task automatic test_55bytes32(input bit with_stall);
      logic [31:0] ed[$];
      clear_q();
      for (int w = 0; w < 13; w++) send32(pat_word(w), 4'b1111, 1'b0);
      send32({pat_word(13)[31:8], 8'hFF}, 4'b1110, 1'b1);
      wait_lst32(2000);
      for (int w = 0; w < 13; w++) ed.push_back(pat_word(w));
      ed.push_back(32'h35363780);
      ed.push_back(32'h0);
      ed.push_back(32'h1B8);
      n_cmp++;
      if (q32_d.size() !== ed.size()) begin
         n_fail++;
         $display("FAIL b55_%0d_count got %0d want %0d", with_stall, q32_d.size(), ed.size());
      end
      for (int i = 0; i < ed.size() && i < q32_d.size(); i++) begin
         n_cmp++;
         if (q32_d[i] !== ed[i] || q32_be[i] !== (i % 16 == 15) || q32_lst[i] !== (i == ed.size() - 1)) begin
            n_fail++;
            $display("FAIL b55_%0d_word%0d got d=%h be=%b lst=%b want d=%h be=%b lst=%b", with_stall, i,
                     q32_d[i], q32_be[i], q32_lst[i], ed[i], (i % 16 == 15), (i == ed.size() - 1));
         end
      end
   endtask

   task automatic test_56bytes32();
      logic [31:0] ed[$];
      clear_q();
      for (int w = 0; w < 13; w++) send32(pat_word(w), 4'b1111, 1'b0);
      send32(pat_word(13), 4'b1111, 1'b1);
      wait_lst32(300);
      for (int w = 0; w < 14; w++) ed.push_back(pat_word(w));
      ed.push_back(32'h80000000);
      repeat (16) ed.push_back(32'h0);
      ed.push_back(32'h1C0);
      n_cmp++;
      if (q32_d.size() !== ed.size()) begin
         n_fail++;
         $display("FAIL b56_count got %0d want %0d", q32_d.size(), ed.size());
      end
      for (int i = 0; i < ed.size() && i < q32_d.size(); i++) begin
         n_cmp++;
         if (q32_d[i] !== ed[i] || q32_be[i] !== (i % 16 == 15) || q32_lst[i] !== (i == ed.size() - 1)) begin
            n_fail++;
            $display("FAIL b56_word%0d got d=%h be=%b lst=%b want d=%h be=%b lst=%b", i,
                     q32_d[i], q32_be[i], q32_lst[i], ed[i], (i % 16 == 15), (i == ed.size() - 1));
         end
      end
   endtask

   task automatic test_empty32();
      logic [31:0] ed[$];
      clear_q();
      send32(32'hDEADBEEF, 4'b0000, 1'b1);
      wait_lst32(200);
      ed.push_back(32'h80000000);
      repeat (15) ed.push_back(32'h0);
      n_cmp++;
      if (q32_d.size() !== ed.size()) begin
         n_fail++;
         $display("FAIL empty32_count got %0d want %0d", q32_d.size(), ed.size());
      end
      for (int i = 0; i < ed.size() && i < q32_d.size(); i++) begin
         n_cmp++;
         if (q32_d[i] !== ed[i] || q32_be[i] !== (i % 16 == 15) || q32_lst[i] !== (i == ed.size() - 1)) begin
            n_fail++;
            $display("FAIL empty32_word%0d got d=%h be=%b lst=%b want d=%h be=%b lst=%b", i,
                     q32_d[i], q32_be[i], q32_lst[i], ed[i], (i % 16 == 15), (i == ed.size() - 1));
         end
      end
   endtask

   task automatic test_abc64();
      logic [63:0] ed[$];
      clear_q();
      send64(64'h616263_1122334455, 8'hE0, 1'b1);
      wait_lst64(200);
      ed.push_back(64'h6162638000000000);
      repeat (6) ed.push_back(64'h0);
      ed.push_back(64'h18);
      n_cmp++;
      if (q64_d.size() !== ed.size()) begin
         n_fail++;
         $display("FAIL abc64_count got %0d want %0d", q64_d.size(), ed.size());
      end
      for (int i = 0; i < ed.size() && i < q64_d.size(); i++) begin
         n_cmp++;
         if (q64_d[i] !== ed[i] || q64_be[i] !== (i % 8 == 7) || q64_lst[i] !== (i == ed.size() - 1)) begin
            n_fail++;
            $display("FAIL abc64_word%0d got d=%h be=%b lst=%b want d=%h be=%b lst=%b", i,
                     q64_d[i], q64_be[i], q64_lst[i], ed[i], (i % 8 == 7), (i == ed.size() - 1));
         end
      end
   endtask

   task automatic test_stall_reset();
      logic [31:0] ed[$];
      rnd32     = 1'b1;
      chk_stall = 1'b1;
      test_55bytes32(1'b1);

      // Abort a message part way through with an asynchronous reset.
      clear_q();
      for (int w = 0; w < 3; w++) send32(pat_word(w), 4'b1111, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (o32_vld !== 1'b0 || o32_d !== 32'h0 || o32_be !== 1'b0 || o32_lst !== 1'b0 ||
          o32_busy !== 1'b0 || m32_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset got vld=%b d=%h be=%b lst=%b busy=%b rdy=%b want 0 0 0 0 0 1",
                  o32_vld, o32_d, o32_be, o32_lst, o32_busy, m32_rdy);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      clear_q();
      send32(32'h61626300, 4'b1110, 1'b1);
      wait_lst32(2000);
      ed.push_back(32'h61626380);
      repeat (14) ed.push_back(32'h0);
      ed.push_back(32'h18);
      n_cmp++;
      if (q32_d.size() !== ed.size()) begin
         n_fail++;
         $display("FAIL postreset_count got %0d want %0d", q32_d.size(), ed.size());
      end
      for (int i = 0; i < ed.size() && i < q32_d.size(); i++) begin
         n_cmp++;
         if (q32_d[i] !== ed[i] || q32_be[i] !== (i % 16 == 15) || q32_lst[i] !== (i == ed.size() - 1)) begin
            n_fail++;
            $display("FAIL postreset_word%0d got d=%h be=%b lst=%b want d=%h be=%b lst=%b", i,
                     q32_d[i], q32_be[i], q32_lst[i], ed[i], (i % 16 == 15), (i == ed.size() - 1));
         end
      end
      chk_stall = 1'b0;
      rnd32     = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      rnd32 = 1'b0; chk_stall = 1'b0;
      rst = 1'b1;
      m32_d = '0; m32_mask = '0; m32_vld = 1'b0; m32_lst = 1'b0;
      m64_d = '0; m64_mask = '0; m64_vld = 1'b0; m64_lst = 1'b0;
      p64_rdy = 1'b1;
      saw_lst32 = 1'b0; saw_lst64 = 1'b0;

      test_reset();
      test_abc32();
      test_55bytes32(1'b0);
      test_56bytes32();
      test_empty32();
      test_abc64();
      test_stall_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
